// File: rtl/fifo_read.sv
// rtl/fifo_read.sv - reads one framed packet from a FIFO and checks its content
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   fifo_rxd   FIFO read data, valid one cycle after fifo_rxen
//   fifo_empty FIFO empty flag
//   fifo_rxen  FIFO read enable, one byte per high cycle
//   fs         frame start (level, held until fd)
//   fd         frame done (level, high in LAST)
//   data_len   packet length in bytes including the 4-byte header
//   part       part number from header bytes 2 (MSB) and 3 (LSB)
//   err        sticky content-mismatch flag, cleared at frame start
//   so         one-hot state code
module fifo_read (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_rxd,
  input  logic        fifo_empty,
  output logic        fifo_rxen,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] data_len,
  output logic [15:0] part,
  output logic        err,
  output logic [7:0]  so
);

  typedef enum logic [7:0] {
    IDLE  = 8'h01,
    PREP  = 8'h02,
    WORK  = 8'h04,
    DRAIN = 8'h08,
    LAST  = 8'h10
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [11:0] len_r;
  logic [11:0] rd_num;
  logic [11:0] chk_num;
  logic        vld;
  logic        chk_en;
  logic        cmp_en;
  logic [7:0]  exp_byte;
  logic        mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fifo_rxen = 1'b0;
    case (state)
      IDLE: begin
        if (fs) state_nx = PREP;
      end
      PREP: begin
        if (!fs)                 state_nx = IDLE;
        else if (data_len == '0) state_nx = LAST;
        else                     state_nx = WORK;
      end
      WORK: begin
        fifo_rxen = !fifo_empty && (rd_num < len_r);
        if (!fs)
          state_nx = IDLE;
        else if (fifo_rxen && (rd_num == len_r - 12'd1))
          state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = fs ? LAST : IDLE;
      end
      LAST: begin
        if (!fs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fd = (state == LAST);
  assign so = state;

  // Bytes landing while the frame is being abandoned (fs low, or already back
  // in IDLE) are dropped without touching err, part or chk_num.
  assign chk_en = vld && fs && ((state == WORK) || (state == DRAIN));

  // Header bytes 2/3 carry the part number and are captured, not compared;
  // payload bytes carry their own index, only the first 128 are checked.
  always_comb begin
    exp_byte = chk_num[7:0];
    cmp_en   = 1'b0;
    if (chk_num == 12'd0) begin
      exp_byte = 8'h55;
      cmp_en   = 1'b1;
    end else if (chk_num == 12'd1) begin
      exp_byte = 8'hAA;
      cmp_en   = 1'b1;
    end else if ((chk_num >= 12'd4) && (chk_num < 12'd128)) begin
      cmp_en   = 1'b1;
    end
  end

  assign mismatch = cmp_en && (fifo_rxd != exp_byte);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r   <= '0;
      rd_num  <= '0;
      chk_num <= '0;
      part    <= '0;
      err     <= 1'b0;
      vld     <= 1'b0;
    end else begin
      vld <= fifo_rxen;
      if ((state == PREP) && fs) begin
        len_r   <= data_len;
        rd_num  <= '0;
        chk_num <= '0;
        part    <= '0;
        err     <= 1'b0;
      end else begin
        if (fifo_rxen) rd_num <= rd_num + 12'd1;
        if (chk_en) begin
          chk_num <= chk_num + 12'd1;
          if (chk_num == 12'd2) part[15:8] <= fifo_rxd;
          if (chk_num == 12'd3) part[7:0]  <= fifo_rxd;
          if (mismatch)         err        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read.sv
// tb/tb_fifo_read.sv - directed self-checking bench for fifo_read
module tb_fifo_read;

  logic        clk;
  logic        rst;
  logic [7:0]  fifo_rxd;
  logic        fifo_empty;
  logic        fifo_rxen;
  logic        fs;
  logic        fd;
  logic [11:0] data_len;
  logic [15:0] part;
  logic        err;
  logic [7:0]  so;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int viol = 0;
  int tcnt = 0;
  logic tog_en = 1'b0;

  fifo_read dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rxd   (fifo_rxd),
    .fifo_empty (fifo_empty),
    .fifo_rxen  (fifo_rxen),
    .fs         (fs),
    .fd         (fd),
    .data_len   (data_len),
    .part       (part),
    .err        (err),
    .so         (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || (tog_en && tcnt[1]);

  // FIFO model: data appears one cycle after the read enable.
  always @(posedge clk) begin
    tcnt <= tcnt + 1;
    if (fifo_rxen && fifo_empty) viol <= viol + 1;
    if (fifo_rxen) begin
      fifo_rxd <= mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
      rd_count <= rd_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_pkt(input int n, input logic [15:0] p, input int bad_idx, input logic [7:0] bad_val);
    for (int i = 0; i < n; i++) begin
      if (i == 0)        mem[i] = 8'h55;
      else if (i == 1)   mem[i] = 8'hAA;
      else if (i == 2)   mem[i] = p[15:8];
      else if (i == 3)   mem[i] = p[7:0];
      else if (i < 128)  mem[i] = i[7:0];
      else               mem[i] = 8'hEE;
    end
    if (bad_idx >= 0) mem[bad_idx] = bad_val;
    rd_ptr   = 0;
    wr_ptr   = n;
    rd_count = 0;
    viol     = 0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (!fd && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, fd}, 32'd1);
  endtask

  task automatic end_frame(input string tag);
    fs = 1'b0;
    @(negedge clk);
    chk(tag, {24'd0, so}, 32'h01);
  endtask

  initial begin
    rst      = 1'b0;
    fs       = 1'b0;
    data_len = 12'd0;
    fifo_rxd = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_so",   {24'd0, so}, 32'h01);
    chk("rst_rxen", {31'd0, fifo_rxen}, 32'd0);
    chk("rst_fd",   {31'd0, fd}, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);
    chk("rst_part", {16'd0, part}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", {24'd0, so}, 32'h01);

    // Basic 8-byte packet
    load_pkt(8, 16'h1234, -1, 8'h00);
    data_len = 12'd8;
    fs = 1'b1;
    wait_fd("p8_fd");
    chk("p8_reads", rd_count, 32'd8);
    chk("p8_part",  {16'd0, part}, 32'h1234);
    chk("p8_err",   {31'd0, err}, 32'd0);
    end_frame("p8_idle");

    // Corrupted payload byte 5
    load_pkt(8, 16'h1234, 5, 8'hFF);
    fs = 1'b1;
    wait_fd("bad_fd");
    chk("bad_err",  {31'd0, err}, 32'd1);
    chk("bad_reads", rd_count, 32'd8);
    end_frame("bad_idle");

    // Zero length: 01 -> 02 -> 10, PREP clears the previous err
    rd_count = 0;
    data_len = 12'd0;
    chk("z_idle", {24'd0, so}, 32'h01);
    fs = 1'b1;
    @(negedge clk);
    chk("z_prep", {24'd0, so}, 32'h02);
    @(negedge clk);
    chk("z_last",  {24'd0, so}, 32'h10);
    chk("z_fd",    {31'd0, fd}, 32'd1);
    chk("z_err",   {31'd0, err}, 32'd0);
    chk("z_reads", rd_count, 32'd0);
    end_frame("z_idle2");

    // 16 bytes with fifo_empty toggling every 2 cycles
    load_pkt(16, 16'hBEEF, -1, 8'h00);
    data_len = 12'd16;
    tog_en = 1'b1;
    fs = 1'b1;
    wait_fd("tog_fd");
    tog_en = 1'b0;
    chk("tog_reads", rd_count, 32'd16);
    chk("tog_viol",  viol, 32'd0);
    chk("tog_err",   {31'd0, err}, 32'd0);
    chk("tog_part",  {16'd0, part}, 32'hBEEF);
    end_frame("tog_idle");

    // Short packet of two bytes: part untouched
    load_pkt(2, 16'h0000, -1, 8'h00);
    data_len = 12'd2;
    fs = 1'b1;
    wait_fd("s2_fd");
    chk("s2_reads", rd_count, 32'd2);
    chk("s2_part",  {16'd0, part}, 32'h0);
    chk("s2_err",   {31'd0, err}, 32'd0);
    end_frame("s2_idle");

    // Abort by dropping fs mid-WORK
    load_pkt(8, 16'h1234, -1, 8'h00);
    data_len = 12'd8;
    fs = 1'b1;
    for (int n = 0; n < 50 && rd_count < 2; n++) @(negedge clk);
    chk("ab_reads", rd_count, 32'd2);
    fs = 1'b0;
    @(negedge clk);
    chk("ab_so", {24'd0, so}, 32'h01);
    repeat (3) @(negedge clk);
    chk("ab_fd",   {31'd0, fd}, 32'd0);
    chk("ab_rxen", {31'd0, fifo_rxen}, 32'd0);

    // Reset mid-WORK after 3 reads, with err already raised
    load_pkt(8, 16'h1234, 1, 8'h00);
    fs = 1'b1;
    for (int n = 0; n < 50 && rd_count < 3; n++) @(negedge clk);
    chk("rw_reads", rd_count, 32'd3);
    chk("rw_err1",  {31'd0, err}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rw_so",   {24'd0, so}, 32'h01);
    chk("rw_rxen", {31'd0, fifo_rxen}, 32'd0);
    chk("rw_err",  {31'd0, err}, 32'd0);
    chk("rw_part", {16'd0, part}, 32'h0);
    fs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fresh frame after reset
    load_pkt(8, 16'h5A3C, -1, 8'h00);
    fs = 1'b1;
    wait_fd("fr_fd");
    chk("fr_reads", rd_count, 32'd8);
    chk("fr_part",  {16'd0, part}, 32'h5A3C);
    chk("fr_err",   {31'd0, err}, 32'd0);
    end_frame("fr_idle");

    // 130 bytes, last two unchecked; data_len changed mid-frame
    load_pkt(130, 16'h0082, -1, 8'h00);
    data_len = 12'd130;
    fs = 1'b1;
    repeat (4) @(negedge clk);
    data_len = 12'd5;
    wait_fd("l130_fd");
    chk("l130_reads", rd_count, 32'd130);
    chk("l130_err",   {31'd0, err}, 32'd0);
    chk("l130_part",  {16'd0, part}, 32'h0082);
    end_frame("l130_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read.md
FIFO_READ -- requirements
Module: fifo_read

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock; all flops rise-edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-low reset (0 = reset).
REQ-004 Port fifo_rxd, input, 8 bits: FIFO read data, valid exactly one cycle after fifo_rxen is high.
REQ-005 Port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-006 Port fifo_rxen, output, 1 bit: FIFO read enable, one byte per high cycle.
REQ-007 Port fs, input, 1 bit: frame start, level; held high by the requester until fd is seen.
REQ-008 Port fd, output, 1 bit: frame done, level.
REQ-009 Port data_len, input, 12 bits: packet length in bytes, including the 4-byte header.
REQ-010 Port part, output, 16 bits: part number captured from header bytes 2 (MSB) and 3 (LSB).
REQ-011 Port err, output, 1 bit: packet content mismatch flag.
REQ-012 Port so, output, 8 bits: current state code.

Function
REQ-013 The state machine SHALL be one-hot with these codes on so: IDLE=0x01, PREP=0x02, WORK=0x04, DRAIN=0x08, LAST=0x10.
REQ-014 IDLE SHALL go to PREP when fs=1; otherwise it stays in IDLE.
REQ-015 PREP SHALL last one cycle: latch data_len into len_r, clear rd_num, chk_num, part and err; then go to WORK, or to LAST if data_len=0.
REQ-016 fifo_rxen SHALL be (state==WORK) && !fifo_empty && (rd_num < len_r); rd_num increments on every fifo_rxen cycle.
REQ-017 WORK SHALL go to DRAIN on the cycle fifo_rxen issues read number len_r (rd_num = len_r-1).
REQ-018 DRAIN SHALL last one cycle (the final byte arrives), then go to LAST.
REQ-019 fd SHALL be (state==LAST); LAST SHALL go to IDLE when fs=0.
REQ-020 vld SHALL be fifo_rxen delayed by one register; on vld the block checks fifo_rxd at index chk_num, then increments chk_num.
REQ-021 Expected bytes: index 0 = 0x55, index 1 = 0xAA, index 2 → part[15:8], index 3 → part[7:0], indices 4..127 = chk_num[7:0], indices ≥128 not checked.
REQ-022 A mismatch SHALL set err; err is sticky until the next PREP, and remains valid while fd is high.
REQ-023 If fs=0 during PREP, WORK or DRAIN, the block SHALL abort to IDLE next cycle: no fd, err and part hold their values, the in-flight byte is discarded.
REQ-024 fifo_empty=1 in WORK SHALL stall reads with no byte lost or duplicated; counters hold.
REQ-025 rd_num and chk_num SHALL be 12 bits and compare against len_r; no wrap is possible because data_len ≤ 4095.
REQ-026 data_len of 1–3 SHALL check only the bytes received; part bytes not received stay 0.
REQ-027 A data_len change after PREP SHALL have no effect on the current frame.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE (so=0x01), fifo_rxen=0, fd=0, err=0, part=0x0000, and clear all counters and vld, including mid-frame.
REQ-029 After rst returns to 1, the first transition SHALL require fs=1 sampled on a clock edge.

Verification
REQ-030 FIFO preloaded 55 AA 12 34 04 05 06 07, data_len=8, fs=1 → exactly 8 fifo_rxen cycles, part=0x1234, err=0, fd=1; fs=0 → so=0x01 next cycle.
REQ-031 Same packet with byte 5 = 0xFF → err=1 by the time fd=1; the next frame's PREP clears err to 0.
REQ-032 fifo_empty toggling 1/0 every 2 cycles during a 16-byte frame → fifo_rxen never high while empty, 16 reads total, err=0.
REQ-033 data_len=0, fs=1 → no fifo_rxen, so sequence 01→02→10, fd=1 two edges after fs is sampled.
REQ-034 rst=0 mid-WORK after 3 reads → so=0x01, fifo_rxen=0, part=0, err=0 asynchronously; a fresh frame then completes correctly.
REQ-035 data_len=130 with bytes 128–129 = 0xEE → err=0, 130 reads, fd=1.
